pps_conditioner: RTL and testbench
==================================

Name: pps_conditioner

Overview:
- Upstream front end for the PPS divider.
- Synchronises the raw GPS PPS input and measures its period against the nominal clock count.
- Rejects glitch edges, and declares lock only after consecutive good periods.
- Drives a clean, fixed-width PPS pulse into the divider's PPS input, plus lock/holdover status for the register block.

Parameters:
- CLK_HZ, 10000000, clocks per nominal PPS period.
- TOL_CLKS, 100, accepted period deviation, ± clocks, inclusive.
- PULSE_CLKS, 1000, o_pps_clean high width in clocks. Must be less than CLK_HZ-TOL_CLKS.
- LOCK_COUNT, 3, consecutive in-window periods required for lock.
- HOLDOVER_MAX, 10, maximum synthetic pulses before lock is dropped.
- CNT_W, 24, period counter width. Must satisfy 2^CNT_W-1 > CLK_HZ+TOL_CLKS.

Ports:
- i_clk_10, in, 1, 10 MHz system clock.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_pps_raw, in, 1, asynchronous raw PPS from receiver.
- o_pps_clean, out, 1, conditioned PPS pulse, to the divider's i_pps_raw.
- o_locked, out, 1, high in LOCKED state.
- o_holdover, out, 1, high in HOLDOVER state.
- o_missing, out, 1, sticky: set on lost reference, cleared on next accepted edge.
- o_period, out, CNT_W, last measured period in clocks.
- o_glitch_cnt, out, 8, saturating count of rejected edges while LOCKED or HOLDOVER.

Behaviour:
- Reset:
  - One clock domain. i_rst_n low asynchronously clears everything: all outputs 0, state ACQUIRE, counter 0, ref_valid 0, good count 0, holdover count 0.
  - Reset release mid-period restarts acquisition from scratch.
- Input path:
  - 3-flop chain s1..s3 on i_pps_raw. edge = s2 & ~s3.
  - edge is high on the 3rd posedge at which i_pps_raw has been sampled high.
  - o_pps_clean rises on the posedge after edge, i.e. 4 cycles latency, then stays high exactly PULSE_CLKS cycles.
- Period counter:
  - Loaded to 1 on an accepted edge (or synthetic pulse); otherwise increments, saturating at all-ones.
  - An edge exactly P cycles after the previous accepted edge sees counter == P.
  - in_window = counter in [CLK_HZ-TOL_CLKS, CLK_HZ+TOL_CLKS].
  - o_period is loaded with counter on every edge while ref_valid.
- ACQUIRE state:
  - Edge with ref_valid=0: set ref_valid, reload counter, good=0.
  - Edge with in_window: good+1; reload counter. When good reaches LOCK_COUNT, go to LOCKED and clear o_missing. No pulse is emitted on the locking edge.
  - Edge out of window: good=0, reload counter (new reference).
  - o_pps_clean stays low throughout ACQUIRE.
- LOCKED state:
  - in_window edge: emit pulse, reload counter, clear o_missing.
  - Out-of-window edge: ignored, counter not reloaded, glitch_cnt+1.
  - Counter == CLK_HZ+TOL_CLKS+1 with no edge: set o_missing, then take the holdover action.
  - An edge on the same cycle the counter equals CLK_HZ+TOL_CLKS is accepted; the boundary is inclusive.
- HOLDOVER state (only with the macro):
  - Counter == CLK_HZ: emit synthetic pulse, reload counter, holdover count+1.
  - in_window edge: back to LOCKED, emit pulse, reload counter, holdover count=0.
  - Out-of-window edge: glitch_cnt+1, ignored.
  - Synthetic pulse count reaching HOLDOVER_MAX: go to ACQUIRE, ref_valid=0.
- Pulse overlap: a pulse request while o_pps_clean is still high cannot occur, given the parameter constraint. Add an assertion for it.
- Glitch counter: o_glitch_cnt saturates at 255 and is cleared only by reset.

Optional Feature:
- Macro: PPS_HOLDOVER_EN.
- Defined: on loss in LOCKED, enter HOLDOVER and emit a synthetic pulse immediately. That first pulse lands TOL_CLKS+1 cycles late; subsequent pulses follow every CLK_HZ.
- Undefined: HOLDOVER state, holdover counter and HOLDOVER_MAX logic are removed. On loss, go directly to ACQUIRE with ref_valid=0. o_holdover is tied 0.

Decomposition:
- Package pps_pkg holds:
  - state encoding constants: ACQUIRE=2'd0, LOCKED=2'd1, HOLDOVER=2'd2;
  - default CLK_HZ;
  - the 24-bit period-count width.
- Natural sub-module: pps_sync_edge, the 3-flop synchroniser with rising-edge output. It is reusable for other async inputs.

Test Plan (sim with CLK_HZ=1000, TOL_CLKS=5, PULSE_CLKS=10, LOCK_COUNT=3, HOLDOVER_MAX=4):
- Acquire: raw edges every 1000 cycles. o_locked rises on the 4th edge. From the 5th edge on, o_pps_clean goes high 4 cycles after each edge, lasting 10 cycles. o_period=1000.
- Window limits: periods 995 and 1005 are accepted. Periods 994 and 1006 are rejected in LOCKED, o_glitch_cnt increments, and no pulse is emitted.
- Glitch: while LOCKED, insert an extra edge 300 cycles after a good one. It is ignored, glitch_cnt=1, and the next edge at 1000 is still accepted.
- Loss with PPS_HOLDOVER_EN: stop edges. At counter 1006 o_missing=1, o_holdover=1 and a pulse is emitted. Pulses follow every 1000 cycles; after the 4th synthetic pulse the block returns to ACQUIRE with o_locked=0. Without the macro, the block goes straight to ACQUIRE at 1006 with no pulse.
- Recovery: during holdover, an edge 1002 cycles after a synthetic pulse returns the block to LOCKED with a pulse and o_missing=0.
- Reset: assert i_rst_n low mid-pulse. Outputs clear immediately, asynchronously. After release, lock needs 4 fresh edges.

Source files
------------

// File: rtl/pps_pkg.sv
// rtl/pps_pkg.sv - shared state encoding and default sizes for the PPS conditioner
package pps_pkg;

    typedef enum logic [1:0] {
        ACQUIRE  = 2'd0,
        LOCKED   = 2'd1,
        HOLDOVER = 2'd2
    } pps_state_t;

    localparam int DEF_CLK_HZ = 10000000;
    localparam int PPS_CNT_W  = 24;

endpackage

// File: rtl/pps_sync_edge.sv
// rtl/pps_sync_edge.sv - 3-flop synchroniser for an async input with registered rising-edge strobe
module pps_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic [2:0] sync_q, sync_d;
    logic       rise_q, rise_d;

    always_comb begin
        sync_d = {sync_q[1:0], i_async};
        rise_d = sync_q[1] & ~sync_q[2];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            rise_q <= rise_d;
        end
    end

    assign o_rise = rise_q;

endmodule

// File: rtl/pps_conditioner.sv
// rtl/pps_conditioner.sv - PPS period qualifier, lock tracker and fixed-width pulse generator
// Define PPS_HOLDOVER_EN to keep emitting synthetic pulses after the reference is lost.
module pps_conditioner
    import pps_pkg::*;
#(
    parameter int CLK_HZ       = DEF_CLK_HZ,
    parameter int TOL_CLKS     = 100,
    parameter int PULSE_CLKS   = 1000,
    parameter int LOCK_COUNT   = 3,
    parameter int HOLDOVER_MAX = 10,
    parameter int CNT_W        = PPS_CNT_W
) (
    input  logic             i_clk_10,
    input  logic             i_rst_n,
    input  logic             i_pps_raw,
    output logic             o_pps_clean,
    output logic             o_locked,
    output logic             o_holdover,
    output logic             o_missing,
    output logic [CNT_W-1:0] o_period,
    output logic [7:0]       o_glitch_cnt
);

    localparam logic [CNT_W-1:0] WIN_LO   = CNT_W'(CLK_HZ - TOL_CLKS);
    localparam logic [CNT_W-1:0] WIN_HI   = CNT_W'(CLK_HZ + TOL_CLKS);
    localparam logic [CNT_W-1:0] LOSS_CNT = CNT_W'(CLK_HZ + TOL_CLKS + 1);
    localparam int GOOD_W  = $clog2(LOCK_COUNT + 1);
    localparam int PULSE_W = $clog2(PULSE_CLKS + 1);
    localparam bit PARAM_OK = (PULSE_CLKS < CLK_HZ - TOL_CLKS) && (LOCK_COUNT >= 1) &&
                              (HOLDOVER_MAX >= 1) &&
                              ((CNT_W >= 32) || (((64'd1 << CNT_W) - 64'd1) > 64'(CLK_HZ + TOL_CLKS)));

    pps_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic [PULSE_W-1:0] pulse_q, pulse_d;
    logic [7:0]         glitch_q, glitch_d;
    logic               ref_valid_q, ref_valid_d;
    logic               missing_q, missing_d;
    logic               pps_edge, in_window, reload, pulse_req, glitch_inc;
`ifdef PPS_HOLDOVER_EN
    localparam logic [CNT_W-1:0] NOM_CNT = CNT_W'(CLK_HZ);
    localparam int HOLD_W = $clog2(HOLDOVER_MAX + 1);
    logic [HOLD_W-1:0]  hold_q, hold_d;
`endif

    pps_sync_edge u_sync (
        .i_clk   (i_clk_10),
        .i_rst_n (i_rst_n),
        .i_async (i_pps_raw),
        .o_rise  (pps_edge)
    );

    assign in_window = (cnt_q >= WIN_LO) && (cnt_q <= WIN_HI);

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        period_d    = period_q;
        good_d      = good_q;
        ref_valid_d = ref_valid_q;
        missing_d   = missing_q;
        reload      = 1'b0;
        pulse_req   = 1'b0;
        glitch_inc  = 1'b0;
`ifdef PPS_HOLDOVER_EN
        hold_d      = hold_q;
`endif
        if (pps_edge && ref_valid_q) begin
            period_d = cnt_q;
        end
        case (state_q)
            ACQUIRE: begin
                if (pps_edge) begin
                    reload = 1'b1;
                    if (!ref_valid_q) begin
                        ref_valid_d = 1'b1;
                        good_d      = '0;
                    end else if (in_window) begin
                        good_d = good_q + GOOD_W'(1);
                        if (good_d == GOOD_W'(LOCK_COUNT)) begin
                            state_d   = LOCKED;
                            missing_d = 1'b0;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (pps_edge && in_window) begin
                    pulse_req = 1'b1;
                    reload    = 1'b1;
                    missing_d = 1'b0;
                end else begin
                    // Out-of-window edges leave the counter running so the next true edge still lines up.
                    glitch_inc = pps_edge;
                    if (cnt_q == LOSS_CNT) begin
                        missing_d = 1'b1;
`ifdef PPS_HOLDOVER_EN
                        pulse_req = 1'b1;
                        reload    = 1'b1;
                        if (HOLDOVER_MAX <= 1) begin
                            state_d     = ACQUIRE;
                            ref_valid_d = 1'b0;
                            good_d      = '0;
                            hold_d      = '0;
                        end else begin
                            state_d = HOLDOVER;
                            hold_d  = HOLD_W'(1);
                        end
`else
                        state_d     = ACQUIRE;
                        ref_valid_d = 1'b0;
                        good_d      = '0;
`endif
                    end
                end
            end
`ifdef PPS_HOLDOVER_EN
            HOLDOVER: begin
                if (pps_edge && in_window) begin
                    state_d   = LOCKED;
                    pulse_req = 1'b1;
                    reload    = 1'b1;
                    hold_d    = '0;
                    missing_d = 1'b0;
                end else begin
                    glitch_inc = pps_edge;
                    if (cnt_q == NOM_CNT) begin
                        pulse_req = 1'b1;
                        reload    = 1'b1;
                        hold_d    = hold_q + HOLD_W'(1);
                        if (hold_d == HOLD_W'(HOLDOVER_MAX)) begin
                            state_d     = ACQUIRE;
                            ref_valid_d = 1'b0;
                            good_d      = '0;
                            hold_d      = '0;
                        end
                    end
                end
            end
`endif
            default: state_d = ACQUIRE;
        endcase
        if (reload) begin
            cnt_d = CNT_W'(1);
        end
        glitch_d = (glitch_inc && glitch_q != 8'hFF) ? glitch_q + 8'd1 : glitch_q;
        if (pulse_req) begin
            pulse_d = PULSE_W'(PULSE_CLKS);
        end else if (pulse_q != '0) begin
            pulse_d = pulse_q - PULSE_W'(1);
        end else begin
            pulse_d = pulse_q;
        end
    end

    always_ff @(posedge i_clk_10 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ACQUIRE;
            cnt_q       <= '0;
            period_q    <= '0;
            good_q      <= '0;
            pulse_q     <= '0;
            glitch_q    <= '0;
            ref_valid_q <= 1'b0;
            missing_q   <= 1'b0;
`ifdef PPS_HOLDOVER_EN
            hold_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            good_q      <= good_d;
            pulse_q     <= pulse_d;
            glitch_q    <= glitch_d;
            ref_valid_q <= ref_valid_d;
            missing_q   <= missing_d;
`ifdef PPS_HOLDOVER_EN
            hold_q      <= hold_d;
`endif
        end
    end

    assign o_pps_clean  = (pulse_q != '0);
    assign o_locked     = (state_q == LOCKED);
`ifdef PPS_HOLDOVER_EN
    assign o_holdover   = (state_q == HOLDOVER);
`else
    assign o_holdover   = 1'b0;
`endif
    assign o_missing    = missing_q;
    assign o_period     = period_q;
    assign o_glitch_cnt = glitch_q;

    a_param_ok: assert property (@(posedge i_clk_10) disable iff (!i_rst_n) PARAM_OK)
        else $error("pps_conditioner: parameter constraints violated");

    a_no_overlap: assert property (@(posedge i_clk_10) disable iff (!i_rst_n) !(pulse_req && o_pps_clean))
        else $error("pps_conditioner: pulse requested while previous pulse still high");

endmodule

// File: tb/tb_pps_conditioner.sv
// tb/tb_pps_conditioner.sv - table-driven scoreboard bench for pps_conditioner
module tb_pps_conditioner;

    localparam int CNT_W = 24;
`ifdef PPS_HOLDOVER_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    typedef struct {
        int gap;
        bit pulse;
        bit locked;
        bit missing;
        bit holdover;
        int glitch;
        int period;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pps_raw = 1'b0;
    logic             pps_clean, locked, holdover, missing;
    logic [CNT_W-1:0] period;
    logic [7:0]       glitch_cnt;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   since_rise = 0;
    int   hi_cnt = 0;
    int   mon_t = 0;
    int   base = 0;
    bit   clean_prev = 1'b0;
    vec_t exp_q[$];
    int   pulse_q[$];
    vec_t tab_a[12];
    vec_t tab_b[10];

    pps_conditioner #(
        .CLK_HZ       (1000),
        .TOL_CLKS     (5),
        .PULSE_CLKS   (10),
        .LOCK_COUNT   (3),
        .HOLDOVER_MAX (4),
        .CNT_W        (CNT_W)
    ) dut (
        .i_clk_10     (clk),
        .i_rst_n      (rst_n),
        .i_pps_raw    (pps_raw),
        .o_pps_clean  (pps_clean),
        .o_locked     (locked),
        .o_holdover   (holdover),
        .o_missing    (missing),
        .o_period     (period),
        .o_glitch_cnt (glitch_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        since_rise++;
    endtask

    task automatic check_state(input string tag, input vec_t v);
        chk({tag, ".clean"},    int'(pps_clean),  int'(v.pulse));
        chk({tag, ".locked"},   int'(locked),     int'(v.locked));
        chk({tag, ".missing"},  int'(missing),    int'(v.missing));
        chk({tag, ".holdover"}, int'(holdover),   int'(v.holdover));
        chk({tag, ".glitch"},   int'(glitch_cnt), v.glitch);
        chk({tag, ".period"},   int'(period),     v.period);
    endtask

    // Raise the raw PPS gap cycles after the previous rise, then compare once the DUT has acted on it.
    task automatic apply_edge(input string tag, input vec_t v);
        vec_t got;
        while (since_rise < v.gap) tick();
        pps_raw    = 1'b1;
        since_rise = 0;
        exp_q.push_back(v);
        if (v.pulse) pulse_q.push_back(cyc + 4);
        tick();
        tick();
        pps_raw = 1'b0;
        tick();
        tick();
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s.scoreboard: got empty queue, required one record", tag);
        end else begin
            checks--;
            got = exp_q.pop_front();
            check_state(tag, got);
        end
    endtask

    initial begin : pulse_monitor
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hi_cnt     = 0;
                clean_prev = 1'b0;
            end else begin
                if (pps_clean && !clean_prev) begin
                    if (pulse_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pulse_time: got rise at cycle %0d, required no pulse", cyc);
                    end else begin
                        mon_t = pulse_q.pop_front();
                        chk("pulse_time", cyc, mon_t);
                    end
                end
                if (pps_clean) begin
                    hi_cnt++;
                end else if (hi_cnt != 0) begin
                    chk("pulse_width", hi_cnt, 10);
                    hi_cnt = 0;
                end
                clean_prev = pps_clean;
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got no finish by %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        //             gap   pls   lck   mis   hold  glt  period
        tab_a[0]  = '{  10, 1'b0, 1'b0, 1'b0, 1'b0, 0,     0};
        tab_a[1]  = '{1000, 1'b0, 1'b0, 1'b0, 1'b0, 0,  1000};
        tab_a[2]  = '{1000, 1'b0, 1'b0, 1'b0, 1'b0, 0,  1000};
        tab_a[3]  = '{1000, 1'b0, 1'b1, 1'b0, 1'b0, 0,  1000};
        tab_a[4]  = '{1000, 1'b1, 1'b1, 1'b0, 1'b0, 0,  1000};
        tab_a[5]  = '{ 995, 1'b1, 1'b1, 1'b0, 1'b0, 0,   995};
        tab_a[6]  = '{1005, 1'b1, 1'b1, 1'b0, 1'b0, 0,  1005};
        tab_a[7]  = '{ 994, 1'b0, 1'b1, 1'b0, 1'b0, 1,   994};
        tab_a[8]  = '{   6, 1'b1, 1'b1, 1'b0, 1'b0, 1,  1000};
        tab_a[9]  = '{ 300, 1'b0, 1'b1, 1'b0, 1'b0, 2,   300};
        tab_a[10] = '{ 700, 1'b1, 1'b1, 1'b0, 1'b0, 2,  1000};
        tab_a[11] = '{1000, 1'b1, 1'b1, 1'b0, 1'b0, 2,  1000};

        tab_b[0]  = '{   5, 1'b0, 1'b0, 1'b0,  1'b0, 0,    0};
        tab_b[1]  = '{1000, 1'b0, 1'b0, 1'b0,  1'b0, 0, 1000};
        tab_b[2]  = '{1000, 1'b0, 1'b0, 1'b0,  1'b0, 0, 1000};
        tab_b[3]  = '{1000, 1'b0, 1'b1, 1'b0,  1'b0, 0, 1000};
        tab_b[4]  = '{1000, 1'b1, 1'b1, 1'b0,  1'b0, 0, 1000};
        tab_b[5]  = '{1006, HOLD, 1'b0, 1'b1,  HOLD, 1, 1006};
        tab_b[6]  = '{1002, HOLD, HOLD, ~HOLD, 1'b0, 1, HOLD ? 1002 : 1006};
        tab_b[7]  = '{1000, HOLD, HOLD, ~HOLD, 1'b0, 1, 1000};
        tab_b[8]  = '{1000, HOLD, HOLD, ~HOLD, 1'b0, 1, 1000};
        tab_b[9]  = '{1000, HOLD, 1'b1, 1'b0,  1'b0, 1, 1000};

        repeat (3) tick();
        check_state("reset", '{0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0});
        rst_n      = 1'b1;
        since_rise = 0;

        for (int i = 0; i < 12; i++) apply_edge($sformatf("a%0d", i), tab_a[i]);

        // Reset in the middle of the pulse from the last table entry.
        tick();
        tick();
        tick();
        chk("pre_reset.clean", int'(pps_clean), 1);
        #2 rst_n = 1'b0;
        #1;
        check_state("async_reset", '{0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0});
        repeat (3) tick();
        rst_n      = 1'b1;
        since_rise = 0;

        for (int i = 0; i < 10; i++) apply_edge($sformatf("b%0d", i), tab_b[i]);

        // Reference stops while locked.
        base = cyc;
        if (HOLD) begin
            for (int k = 0; k < 4; k++) pulse_q.push_back(base + 1006 + 1000 * k);
        end
        while (cyc < base + 1005) tick();
        chk("loss_pre.missing", int'(missing), 0);
        chk("loss_pre.locked",  int'(locked),  1);
        tick();
        chk("loss.missing",  int'(missing),  1);
        chk("loss.locked",   int'(locked),   0);
        chk("loss.holdover", int'(holdover), int'(HOLD));
        while (cyc < base + 4005) tick();
        chk("hold_end_pre.holdover", int'(holdover), int'(HOLD));
        chk("hold_end_pre.locked",   int'(locked),   0);
        tick();
        chk("hold_end.holdover", int'(holdover), 0);
        chk("hold_end.locked",   int'(locked),   0);
        chk("hold_end.missing",  int'(missing),  1);
        repeat (30) tick();
        chk("pulse_queue_empty", pulse_q.size(), 0);
        chk("edge_queue_empty",  exp_q.size(),   0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
